data_sram_responder: RTL and testbench

- Memory-side responder for the CPU data port's request/response (sram-like) handshake.
- Accepts load and store requests from the execute/memory stages and commits stores with byte strobes.
- Returns load data in order with a programmable latency, so MEM-stage load extraction and pipeline stalls are exercised against a non-zero-latency memory.
- Used as the data memory in simulation and FPGA bring-up builds.

---
 rtl/data_sram_responder.sv | 169 ++++++++++++++++
 tb/tb_data_sram_responder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: accepts loads/stores on an sram-like handshake and
// answers in order after a programmable latency. Optional random extra delay and
// acceptance stalls are enabled by defining DSRAM_RAND_DELAY_EN.
module data_sram_responder #(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 2,
   parameter int LAT    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int DLY_W = $clog2(LAT + 4);
   localparam int WORDS = 1 << ADDR_W;

   logic [31:0]       mem_q [WORDS];

   logic              q_wr_q   [DEPTH];
   logic              q_wr_d   [DEPTH];
   logic [31:0]       q_data_q [DEPTH];
   logic [31:0]       q_data_d [DEPTH];
   logic [DLY_W-1:0]  q_cnt_q  [DEPTH];
   logic [DLY_W-1:0]  q_cnt_d  [DEPTH];

   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [ADDR_W-1:0] idx_s;
   logic              addr_ok_s;
   logic              accept_s;
   logic              pop_s;
   logic [DLY_W-1:0]  push_cnt_s;
   logic [31:0]       merged_s;
   logic              unused_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return '0;
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   // Requester guarantees alignment and size/strobe consistency, and the upper
   // address bits simply alias.
   assign unused_ok = ^{size, addr[31:ADDR_W+2], addr[1:0], q_wr_q[head_q]};
   assign idx_s     = addr[ADDR_W+1:2];

`ifdef DSRAM_RAND_DELAY_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign addr_ok_s  = !reset && (count_q != CNT_W'(DEPTH)) && !lfsr_q[2];
   assign push_cnt_s = DLY_W'(LAT - 1) + DLY_W'(lfsr_q[1:0]);
`else
   assign addr_ok_s  = !reset && (count_q != CNT_W'(DEPTH));
   assign push_cnt_s = DLY_W'(LAT - 1);
`endif

   assign accept_s = req && addr_ok_s;
   // Only the head may answer; a ready younger entry waits its turn.
   assign pop_s    = !reset && (count_q != CNT_W'(0)) && (q_cnt_q[head_q] == DLY_W'(0));

   assign addr_ok = addr_ok_s;
   assign data_ok = pop_s;
   assign rdata   = pop_s ? q_data_q[head_q] : 32'h0000_0000;

   always_comb begin
      for (int b = 0; b < 4; b++) begin
         if (wstrb[b]) begin
            merged_s[8*b +: 8] = wdata[8*b +: 8];
         end else begin
            merged_s[8*b +: 8] = mem_q[idx_s][8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept_s && wr) begin
         mem_q[idx_s] <= merged_s;
      end else begin
         mem_q[idx_s] <= mem_q[idx_s];
      end
   end

   always_comb begin
      q_wr_d   = q_wr_q;
      q_data_d = q_data_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (q_cnt_q[i] != DLY_W'(0)) begin
            q_cnt_d[i] = q_cnt_q[i] - DLY_W'(1);
         end else begin
            q_cnt_d[i] = q_cnt_q[i];
         end
      end
      tail_d = tail_q;
      head_d = head_q;

      // Load data is captured at acceptance; store responses always carry zero.
      if (accept_s) begin
         q_wr_d[tail_q]   = wr;
         q_data_d[tail_q] = wr ? 32'h0000_0000 : mem_q[idx_s];
         q_cnt_d[tail_q]  = push_cnt_s;
         tail_d           = ptr_inc(tail_q);
      end else begin
         tail_d = tail_q;
      end

      if (pop_s) begin
         head_d = ptr_inc(head_q);
      end else begin
         head_d = head_q;
      end

      case ({accept_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            q_cnt_q[i] <= '0;
         end
      end else begin
         q_cnt_q <= q_cnt_d;
      end
      q_wr_q   <= q_wr_d;
      q_data_q <= q_data_d;
   end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench: a cycle table on the default instance plus a hand-written
// full-queue sequence on a LAT=4 instance.
module tb_data_sram_responder;

   logic        clk;
   logic        reset;
   logic        req_a, wr_a, req_b, wr_b;
   logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
   logic [3:0]  wstrb_a, wstrb_b;
   logic        aok_a, dok_a, aok_b, dok_b;
   logic [31:0] rd_a, rd_b;

   int n_cmp = 0;
   int n_bad = 0;

   data_sram_responder u_dut_a (
      .clk(clk), .reset(reset), .req(req_a), .wr(wr_a), .size(2'b10),
      .addr(addr_a), .wstrb(wstrb_a), .wdata(wdata_a),
      .addr_ok(aok_a), .data_ok(dok_a), .rdata(rd_a)
   );

   data_sram_responder #(.ADDR_W(12), .DEPTH(2), .LAT(4)) u_dut_b (
      .clk(clk), .reset(reset), .req(req_b), .wr(wr_b), .size(2'b10),
      .addr(addr_b), .wstrb(wstrb_b), .wdata(wdata_b),
      .addr_ok(aok_b), .data_ok(dok_b), .rdata(rd_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic        rst;
      logic        req;
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic        aok;
      logic        dok;
      logic [31:0] rd;
   } vec_t;

   localparam int NV = 27;
   vec_t vt [NV];

   function automatic vec_t mk(input logic rst, input logic rq, input logic w,
                               input logic [31:0] a, input logic [3:0] s,
                               input logic [31:0] d, input logic aok,
                               input logic dok, input logic [31:0] rd);
      vec_t v;
      v.rst = rst; v.req = rq; v.wr = w; v.addr = a; v.wstrb = s; v.wdata = d;
      v.aok = aok; v.dok = dok; v.rd = rd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive_b(input logic rq, input logic w, input logic [31:0] a,
                          input logic [31:0] d);
      req_b = rq; wr_b = w; addr_b = a; wstrb_b = 4'hF; wdata_b = d;
   endtask

   logic [31:0] la [3];
   logic [31:0] lr [3];
   logic        ea [11];
   logic        ed [11];
   logic [31:0] er [11];
   int          k;

   initial begin
      reset = 1'b1;
      req_a = 1'b0; wr_a = 1'b0; addr_a = 32'h0; wstrb_a = 4'h0; wdata_a = 32'h0;
      drive_b(1'b0, 1'b0, 32'h0, 32'h0);

      //              rst   req   wr    addr          wstrb  wdata          aok   dok   rdata
      vt[0]  = mk(1'b1, 1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'h0,         1'b0, 1'b0, 32'h0);
      vt[1]  = mk(1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 32'h0,         1'b0, 1'b0, 32'h0);
      vt[2]  = mk(1'b0, 1'b1, 1'b1, 32'h0000_0040, 4'hF, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
      vt[3]  = mk(1'b0, 1'b1, 1'b1, 32'h0000_0044, 4'hF, 32'h1122_3344, 1'b1, 1'b0, 32'h0);
      vt[4]  = mk(1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 32'h0,         1'b0, 1'b1, 32'h0);
      vt[5]  = mk(1'b0, 1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'h0,         1'b1, 1'b1, 32'h0);
      vt[6]  = mk(1'b0, 1'b1, 1'b1, 32'h0000_0047, 4'h8, 32'hAB00_0000, 1'b1, 1'b0, 32'h0);
      vt[7]  = mk(1'b0, 1'b1, 1'b0, 32'h0000_0044, 4'h0, 32'h0,         1'b0, 1'b1, 32'h1234_5678);
      vt[8]  = mk(1'b0, 1'b1, 1'b0, 32'h0000_0044, 4'h0, 32'h0,         1'b1, 1'b1, 32'h0);
      vt[9]  = mk(1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 32'h0,         1'b1, 1'b0, 32'h0);
      vt[10] = mk(1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 32'h0,         1'b1, 1'b1, 32'hAB22_3344);
      vt[11] = mk(1'b0, 1'b1, 1'b0, 32'h0000_4044, 4'h0, 32'h0,         1'b1, 1'b0, 32'h0);
      vt[12] = mk(1'b0, 1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'h0,         1'b1, 1'b0, 32'h0);
      vt[13] = mk(1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 32'h0,         1'b0, 1'b1, 32'hAB22_3344);
      vt[14] = mk(1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 32'h0,         1'b1, 1'b1, 32'h1234_5678);
      vt[15] = mk(1'b0, 1'b1, 1'b1, 32'h0000_0040, 4'h3, 32'h0000_BEEF, 1'b1, 1'b0, 32'h0);
      vt[16] = mk(1'b0, 1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'h0,         1'b1, 1'b0, 32'h0);
      vt[17] = mk(1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 32'h0,         1'b0, 1'b1, 32'h0);
      vt[18] = mk(1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 32'h0,         1'b1, 1'b1, 32'h1234_BEEF);
      vt[19] = mk(1'b0, 1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'h0,         1'b1, 1'b0, 32'h0);
      vt[20] = mk(1'b0, 1'b1, 1'b0, 32'h0000_0044, 4'h0, 32'h0,         1'b1, 1'b0, 32'h0);
      vt[21] = mk(1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 32'h0,         1'b0, 1'b0, 32'h0);
      vt[22] = mk(1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 32'h0,         1'b1, 1'b0, 32'h0);
      vt[23] = mk(1'b0, 1'b1, 1'b0, 32'h0000_0044, 4'h0, 32'h0,         1'b1, 1'b0, 32'h0);
      vt[24] = mk(1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 32'h0,         1'b1, 1'b0, 32'h0);
      vt[25] = mk(1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 32'h0,         1'b1, 1'b1, 32'hAB22_3344);
      vt[26] = mk(1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 32'h0,         1'b1, 1'b0, 32'h0);

      for (int i = 0; i < NV; i++) begin
         @(posedge clk);
         #1;
         reset = vt[i].rst; req_a = vt[i].req; wr_a = vt[i].wr; addr_a = vt[i].addr;
         wstrb_a = vt[i].wstrb; wdata_a = vt[i].wdata;
         #1;
         chk($sformatf("row%0d addr_ok", i), {31'h0, aok_a}, {31'h0, vt[i].aok});
         chk($sformatf("row%0d data_ok", i), {31'h0, dok_a}, {31'h0, vt[i].dok});
         chk($sformatf("row%0d rdata", i), rd_a, vt[i].rd);
      end
      req_a = 1'b0;

      // LAT=4 instance: fill two words, then let both store responses drain.
      @(posedge clk); #1; drive_b(1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D);
      #1; chk("b_st0 addr_ok", {31'h0, aok_b}, 32'h1);
      @(posedge clk); #1; drive_b(1'b1, 1'b1, 32'h0000_0104, 32'h0BAD_BEEF);
      #1; chk("b_st1 addr_ok", {31'h0, aok_b}, 32'h1);
      for (int t = 2; t < 6; t++) begin
         @(posedge clk); #1; drive_b(1'b0, 1'b0, 32'h0, 32'h0);
         #1;
         chk($sformatf("b_drain%0d addr_ok", t), {31'h0, aok_b}, {31'h0, (t == 5)});
         chk($sformatf("b_drain%0d data_ok", t), {31'h0, dok_b}, {31'h0, (t >= 4)});
         chk($sformatf("b_drain%0d rdata", t), rd_b, 32'h0);
      end

      // Three back-to-back loads into a two-deep queue.
      la[0] = 32'h0000_0100; la[1] = 32'h0000_0104; la[2] = 32'h0000_0100;
      lr[0] = 32'hCAFE_F00D; lr[1] = 32'h0BAD_BEEF; lr[2] = 32'hCAFE_F00D;
      for (int c = 0; c < 11; c++) begin
         ea[c] = !(c >= 2 && c <= 4);
         ed[c] = (c == 4) || (c == 5) || (c == 9);
         er[c] = 32'h0;
      end
      er[4] = lr[0]; er[5] = lr[1]; er[9] = lr[2];
      k = 0;
      for (int c = 0; c < 11; c++) begin
         @(posedge clk); #1;
         if (k < 3) drive_b(1'b1, 1'b0, la[k], 32'h0);
         else       drive_b(1'b0, 1'b0, 32'h0, 32'h0);
         #1;
         chk($sformatf("full c%0d addr_ok", c), {31'h0, aok_b}, {31'h0, ea[c]});
         chk($sformatf("full c%0d data_ok", c), {31'h0, dok_b}, {31'h0, ed[c]});
         chk($sformatf("full c%0d rdata", c), rd_b, er[c]);
         if (k < 3 && ea[c]) k++;
      end
      drive_b(1'b0, 1'b0, 32'h0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
